// File: rtl/shift_amount_detector.sv
// Iterative inverse of a bidirectional logical barrel shifter.
// Each cycle tests one candidate amount, checking both directions.
module shift_amount_detector #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2**N-1:0]  a,
    input  logic [2**N-1:0]  y,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [N-1:0]     amt,
    output logic             lr
);

    localparam int W = 2**N;
    localparam logic [N-1:0] K_LAST = N'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t         state, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   y_q, y_d;
    logic [N-1:0]   k, k_d;
    logic           found_d;
    logic [N-1:0]   amt_d;
    logic           lr_d;
    logic           r_hit, l_hit;

    // Shifted results are truncated to W bits by the comparison context.
    assign r_hit = ((a_q >> k) == y_q);
    assign l_hit = ((a_q << k) == y_q);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            a_q   <= '0;
            y_q   <= '0;
            k     <= '0;
            found <= 1'b0;
            amt   <= '0;
            lr    <= 1'b0;
        end else begin
            state <= state_d;
            a_q   <= a_d;
            y_q   <= y_d;
            k     <= k_d;
            found <= found_d;
            amt   <= amt_d;
            lr    <= lr_d;
        end
    end

    always_comb begin
        state_d = state;
        a_d     = a_q;
        y_d     = y_q;
        k_d     = k;
        found_d = found;
        amt_d   = amt;
        lr_d    = lr;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    y_d     = y;
                    k_d     = '0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // Right wins over left at the same candidate amount.
                if (r_hit) begin
                    found_d = 1'b1;
                    amt_d   = k;
                    lr_d    = 1'b0;
                    state_d = S_DONE;
                end else if (l_hit) begin
                    found_d = 1'b1;
                    amt_d   = k;
                    lr_d    = 1'b1;
                    state_d = S_DONE;
                end else if (k == K_LAST) begin
                    found_d = 1'b0;
                    amt_d   = '0;
                    lr_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    k_d = k + N'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_amount_detector.sv
// Directed-vector bench for shift_amount_detector (N = 3, W = 8).
module tb_shift_amount_detector;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] amt;
    logic       lr;

    int n_cmp;
    int n_err;

    shift_amount_detector #(.N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .found (found),
        .amt   (amt),
        .lr    (lr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] y;
        logic       f;
        logic [2:0] amt;
        logic       lr;
        int         lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns on the negedge after the start edge E.
    task automatic launch(input logic [7:0] av, input logic [7:0] yv);
        @(negedge clk);
        a = av;
        y = yv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts edges after E until done is seen; bounded.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        logic saw_done;
        n_cmp = 0;
        n_err = 0;

        tbl[0] = '{8'hB6, 8'h16, 1'b1, 3'd3, 1'b0, 4};
        tbl[1] = '{8'h0F, 8'hF0, 1'b1, 3'd4, 1'b1, 5};
        tbl[2] = '{8'hA5, 8'hA5, 1'b1, 3'd0, 1'b0, 1};
        tbl[3] = '{8'h10, 8'h00, 1'b1, 3'd4, 1'b1, 5};
        tbl[4] = '{8'h81, 8'h00, 1'b0, 3'd0, 1'b0, 8};
        tbl[5] = '{8'h80, 8'h01, 1'b1, 3'd7, 1'b0, 8};
        tbl[6] = '{8'h01, 8'h80, 1'b1, 3'd7, 1'b1, 8};
        tbl[7] = '{8'h3C, 8'h1E, 1'b1, 3'd1, 1'b0, 2};
        tbl[8] = '{8'h01, 8'h03, 1'b0, 3'd0, 1'b0, 8};
        tbl[9] = '{8'hFF, 8'h0F, 1'b1, 3'd4, 1'b0, 5};

        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        y     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, found, amt == 3'd0, lr},
              32'h2);
        check("reset_amt", {29'd0, amt}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            launch(tbl[i].a, tbl[i].y);
            wait_done(0, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcnt, tbl[i].lat + 1);
            check($sformatf("v%0d_found", i), {31'd0, found}, {31'd0, tbl[i].f});
            check($sformatf("v%0d_amt", i), {29'd0, amt}, {29'd0, tbl[i].amt});
            check($sformatf("v%0d_lr", i), {31'd0, lr}, {31'd0, tbl[i].lr});
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_after_done", i),
                  {27'd0, busy, done, found, lr, 1'b0},
                  {27'd0, 1'b0, 1'b0, tbl[i].f, tbl[i].lr, 1'b0});
            check($sformatf("v%0d_amt_hold", i), {29'd0, amt}, {29'd0, tbl[i].amt});
        end

        // Start pulse during SEARCH must be ignored.
        launch(8'h0F, 8'hF0);
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        y = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(2, lat, bcnt);
        check("ign_latency", lat, 5);
        check("ign_result", {27'd0, found, amt, lr}, {27'd0, 1'b1, 3'd4, 1'b1});

        // Reset at k = 2 clears everything immediately.
        launch(8'h0F, 8'hF0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {26'd0, busy, done, found, amt, lr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_mid_no_done", {31'd0, saw_done}, 32'd0);

        launch(8'hB6, 8'h16);
        wait_done(0, lat, bcnt);
        check("post_rst_latency", lat, 4);
        check("post_rst_result", {27'd0, found, amt, lr}, {27'd0, 1'b1, 3'd3, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
